// File: rtl/wb_pkg.sv
// Shared writeback-stage types: writeback source select and load size/sign codes.
package wb_pkg;

  typedef enum logic [2:0] {
    PC4   = 3'd0,
    PCIMM = 3'd1,
    IMM   = 3'd2,
    ALU   = 3'd3,
    MEM   = 3'd4
  } wb_sel_e;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LD  = 3'd3;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] LWU = 3'd6;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load data extraction: picks the addressed field from the aligned word,
// sign/zero-extends it, and flags misaligned accesses.
module load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  // Byte offset uses only the bits that index within one XLEN word.
  localparam int OFFW = (XLEN == 64) ? 3 : 2;

  logic [OFFW-1:0] off;
  logic [XLEN-1:0] sh;
  logic            unused_addr;

  assign off         = addr_lo[OFFW-1:0];
  assign sh          = raw >> {off, 3'b000};
  assign unused_addr = ^addr_lo;

  always_comb begin
    data       = raw;
    misaligned = (off != '0);
    case (funct3)
      LB: begin
        data       = XLEN'($signed(sh[7:0]));
        misaligned = 1'b0;
      end
      LBU: begin
        data       = XLEN'(sh[7:0]);
        misaligned = 1'b0;
      end
      LH: begin
        data       = XLEN'($signed(sh[15:0]));
        misaligned = addr_lo[0];
      end
      LHU: begin
        data       = XLEN'(sh[15:0]);
        misaligned = addr_lo[0];
      end
      LW: begin
        data       = XLEN'($signed(sh[31:0]));
        misaligned = (addr_lo[1:0] != 2'b00);
      end
      LWU: begin
        // Only a real opcode on RV64; on RV32 it falls back to a full-width load.
        if (XLEN == 64) begin
          data       = XLEN'(sh[31:0]);
          misaligned = (addr_lo[1:0] != 2'b00);
        end
      end
      default: begin
        data = raw;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with writeback-source select, register-file
// write port / forwarding bus, and retired-instruction counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   alu_out,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic [2:0]        mem_addr_lo,
  input  logic [2:0]        funct3,
  input  logic [2:0]        wb_sel,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              rd_we,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  instret
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   rdata;
    logic [2:0]        addr_lo;
    logic [2:0]        funct3;
    logic [2:0]        sel;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
  } wb_ent_t;

  wb_ent_t         ent_q;
  logic            valid_q;
  logic            retire;
  logic [XLEN-1:0] ld_data;
  logic            ld_mis;
  logic [XLEN-1:0] wdata;

  assign in_ready = !stall;
  assign retire   = valid_q && !stall && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
      instret <= '0;
    end else begin
      if (retire) instret <= instret + CNT_W'(1);
      // Flush beats stall; a held entry is dropped without retiring.
      if (flush) begin
        valid_q <= 1'b0;
      end else if (!stall) begin
        valid_q <= in_valid;
        if (in_valid) begin
          ent_q.pc      <= pc;
          ent_q.imm     <= imm;
          ent_q.alu     <= alu_out;
          ent_q.rdata   <= mem_rdata;
          ent_q.addr_lo <= mem_addr_lo;
          ent_q.funct3  <= funct3;
          ent_q.sel     <= wb_sel;
          ent_q.rd      <= rd_addr;
          ent_q.rd_we   <= rd_we;
        end
      end
    end
  end

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .raw        (ent_q.rdata),
    .addr_lo    (ent_q.addr_lo),
    .funct3     (ent_q.funct3),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  always_comb begin
    wdata = ent_q.alu;
    case (ent_q.sel)
      PC4:     wdata = ent_q.pc + XLEN'(4);
      PCIMM:   wdata = ent_q.pc + ent_q.imm;
      IMM:     wdata = ent_q.imm;
      ALU:     wdata = ent_q.alu;
      MEM:     wdata = ld_data;
      default: wdata = ent_q.alu;
    endcase
  end

  // Misaligned loads suppress the write but still retire.
  assign misalign_err = valid_q && (ent_q.sel == MEM) && ld_mis;
  assign rf_we        = valid_q && ent_q.rd_we && (ent_q.rd != '0) && !misalign_err;
  assign rf_waddr     = ent_q.rd;
  assign rf_wdata     = valid_q ? wdata : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, hand sequences for
// reset/stall/flush/counter wrap, and a randomized run against a reference model.
module tb_wb_stage;
  import wb_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n, in_valid, stall, flush, rd_we;
  logic [XLEN-1:0]   pc, imm, alu_out, mem_rdata;
  logic [2:0]        mem_addr_lo, funct3, wb_sel;
  logic [REG_AW-1:0] rd_addr;

  logic              in_ready, rf_we, misalign_err;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic [63:0]       instret;

  logic              in_ready_w, rf_we_w, misalign_err_w;
  logic [REG_AW-1:0] rf_waddr_w;
  logic [XLEN-1:0]   rf_wdata_w;
  logic [3:0]        instret_w;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .pc(pc), .imm(imm), .alu_out(alu_out),
    .mem_rdata(mem_rdata), .mem_addr_lo(mem_addr_lo), .funct3(funct3),
    .wb_sel(wb_sel), .rd_addr(rd_addr), .rd_we(rd_we), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .misalign_err(misalign_err),
    .instret(instret)
  );

  wb_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .stall(stall), .flush(flush), .pc(pc), .imm(imm), .alu_out(alu_out),
    .mem_rdata(mem_rdata), .mem_addr_lo(mem_addr_lo), .funct3(funct3),
    .wb_sel(wb_sel), .rd_addr(rd_addr), .rd_we(rd_we), .rf_we(rf_we_w),
    .rf_waddr(rf_waddr_w), .rf_wdata(rf_wdata_w), .misalign_err(misalign_err_w),
    .instret(instret_w)
  );

  // Reference model: the instruction currently in WB plus a retirement count.
  bit              m_valid;
  logic [XLEN-1:0] m_pc, m_imm, m_alu, m_rdata;
  int              m_lo, m_f3, m_sel, m_rd;
  bit              m_rdwe;
  longint unsigned m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Load result from the byte-lane rules, using integer arithmetic.
  function automatic logic [31:0] ld_model(input logic [31:0] w, input int lo, input int f3,
                                          output bit mis);
    int              bytes, off;
    bit              sgn;
    longint unsigned v;
    case (f3)
      0:       begin bytes = 1; sgn = 1; end
      4:       begin bytes = 1; sgn = 0; end
      1:       begin bytes = 2; sgn = 1; end
      5:       begin bytes = 2; sgn = 0; end
      default: begin bytes = 4; sgn = 0; end
    endcase
    off = lo % 4;
    mis = (off % bytes) != 0;
    v = (longint'(w) >> (8 * off)) % (64'd1 << (8 * bytes));
    if (sgn && v >= (64'd1 << (8 * bytes - 1))) v = v + ~((64'd1 << (8 * bytes)) - 1);
    return v[31:0];
  endfunction

  task automatic model_exp(output bit we, output logic [31:0] wd, output bit mis);
    bit lmis;
    logic [31:0] ld;
    ld  = ld_model(m_rdata, m_lo, m_f3, lmis);
    case (m_sel)
      0:       wd = m_pc + 32'd4;
      1:       wd = m_pc + m_imm;
      2:       wd = m_imm;
      4:       wd = ld;
      default: wd = m_alu;
    endcase
    mis = m_valid && m_sel == 4 && lmis;
    we  = m_valid && m_rdwe && m_rd != 0 && !mis;
    if (!m_valid) wd = 32'd0;
  endtask

  task automatic tick();
    bit     nv, ret;
    ret = m_valid && !stall && !flush;
    nv  = m_valid;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_pc = 0; m_imm = 0; m_alu = 0; m_rdata = 0;
      m_lo = 0; m_f3 = 0; m_sel = 0; m_rd = 0; m_rdwe = 0; m_cnt = 0;
    end else begin
      if (ret) m_cnt++;
      if (flush) nv = 0;
      else if (!stall) begin
        nv = in_valid;
        if (in_valid) begin
          m_pc = pc; m_imm = imm; m_alu = alu_out; m_rdata = mem_rdata;
          m_lo = mem_addr_lo; m_f3 = funct3; m_sel = wb_sel;
          m_rd = rd_addr; m_rdwe = rd_we;
        end
      end
      m_valid = nv;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    bit we, mis;
    logic [31:0] wd;
    model_exp(we, wd, mis);
    chk({tag, ".rf_we"}, rf_we, we);
    chk({tag, ".rf_waddr"}, rf_waddr, m_rd);
    if (!mis) chk({tag, ".rf_wdata"}, rf_wdata, wd);
    chk({tag, ".misalign_err"}, misalign_err, mis);
    chk({tag, ".instret"}, instret, m_cnt);
    chk({tag, ".instret_w4"}, instret_w, m_cnt % 16);
    chk({tag, ".in_ready"}, in_ready, !stall);
  endtask

  task automatic drive(input logic [2:0] sel, input logic [2:0] f3, input logic [2:0] lo,
                       input logic [31:0] rdata, input logic [31:0] p, input logic [31:0] im,
                       input logic [31:0] al, input logic [4:0] rd);
    in_valid = 1; wb_sel = sel; funct3 = f3; mem_addr_lo = lo; mem_rdata = rdata;
    pc = p; imm = im; alu_out = al; rd_addr = rd; rd_we = 1;
  endtask

  typedef struct {
    logic [2:0]  sel, f3, lo;
    logic [31:0] rdata, pc, imm, alu;
    logic [4:0]  rd;
    logic [31:0] exp_wd;
    bit          exp_we, exp_mis;
  } vec_t;

  vec_t vecs[14];
  logic [31:0] held_wd;
  longint unsigned held_cnt;
  int f3_pick[5] = '{0, 1, 2, 4, 5};

  initial begin
    vecs[0]  = '{3'd0, 3'd0, 3'd0, 32'h0, 32'h100, 32'h20, 32'h55, 5'd5, 32'h104, 1, 0};
    vecs[1]  = '{3'd1, 3'd0, 3'd0, 32'h0, 32'h100, 32'h20, 32'h55, 5'd5, 32'h120, 1, 0};
    vecs[2]  = '{3'd2, 3'd0, 3'd0, 32'h0, 32'h100, 32'h20, 32'h55, 5'd5, 32'h20, 1, 0};
    vecs[3]  = '{3'd3, 3'd0, 3'd0, 32'h0, 32'h100, 32'h20, 32'h55, 5'd5, 32'h55, 1, 0};
    vecs[4]  = '{3'd4, 3'd0, 3'd3, 32'h80FF7F01, 0, 0, 0, 5'd7, 32'hFFFFFF80, 1, 0};
    vecs[5]  = '{3'd4, 3'd4, 3'd3, 32'h80FF7F01, 0, 0, 0, 5'd7, 32'h00000080, 1, 0};
    vecs[6]  = '{3'd4, 3'd1, 3'd2, 32'h80FF7F01, 0, 0, 0, 5'd7, 32'hFFFF80FF, 1, 0};
    vecs[7]  = '{3'd4, 3'd2, 3'd1, 32'h80FF7F01, 0, 0, 0, 5'd7, 32'h0, 0, 1};
    vecs[8]  = '{3'd3, 3'd0, 3'd0, 32'h0, 0, 0, 32'h55, 5'd0, 32'h55, 0, 0};
    vecs[9]  = '{3'd0, 3'd0, 3'd0, 32'h0, 32'hFFFFFFFC, 0, 0, 5'd9, 32'h0, 1, 0};
    vecs[10] = '{3'd7, 3'd0, 3'd0, 32'h0, 32'h40, 32'h8, 32'h1234, 5'd3, 32'h1234, 1, 0};
    vecs[11] = '{3'd4, 3'd5, 3'd0, 32'h80FF7F01, 0, 0, 0, 5'd1, 32'h00007F01, 1, 0};
    vecs[12] = '{3'd4, 3'd2, 3'd0, 32'h80FF7F01, 0, 0, 0, 5'd1, 32'h80FF7F01, 1, 0};
    vecs[13] = '{3'd4, 3'd1, 3'd1, 32'h80FF7F01, 0, 0, 0, 5'd2, 32'h0, 0, 1};

    rst_n = 0; stall = 0; flush = 0;
    drive(3'd3, 3'd0, 3'd0, 32'h0, 32'h100, 32'h0, 32'hABCD, 5'd4);

    // Reset held for two edges with in_valid asserted.
    tick(); tick();
    chk("reset.rf_we", rf_we, 0);
    chk("reset.rf_wdata", rf_wdata, 0);
    chk("reset.instret", instret, 0);
    chk("reset.misalign_err", misalign_err, 0);
    check_all("reset");
    rst_n = 1;
    tick();
    chk("first_capture.rf_wdata", rf_wdata, 32'hABCD);
    chk("first_capture.rf_we", rf_we, 1);
    check_all("first_capture");

    // Directed vector table, back-to-back.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].sel, vecs[i].f3, vecs[i].lo, vecs[i].rdata, vecs[i].pc, vecs[i].imm,
            vecs[i].alu, vecs[i].rd);
      tick();
      if (!vecs[i].exp_mis) chk($sformatf("vec%0d.rf_wdata", i), rf_wdata, vecs[i].exp_wd);
      chk($sformatf("vec%0d.rf_we", i), rf_we, vecs[i].exp_we);
      chk($sformatf("vec%0d.misalign_err", i), misalign_err, vecs[i].exp_mis);
      check_all($sformatf("vec%0d", i));
    end

    // Stall holds the entry for 3 cycles, then flush+stall drops it.
    drive(3'd1, 3'd0, 3'd0, 0, 32'h200, 32'h10, 0, 5'd6);
    tick();
    held_wd = rf_wdata; held_cnt = m_cnt;
    chk("hold.captured", rf_wdata, 32'h210);
    stall = 1;
    drive(3'd3, 3'd0, 3'd0, 0, 0, 0, 32'hDEAD, 5'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.rf_wdata", rf_wdata, held_wd);
      chk("stall.rf_we", rf_we, 1);
      chk("stall.in_ready", in_ready, 0);
      chk("stall.instret", instret, held_cnt);
      check_all("stall");
    end
    flush = 1;
    tick();
    chk("flush.rf_we", rf_we, 0);
    chk("flush.instret", instret, held_cnt);
    check_all("flush");
    stall = 0; flush = 0; in_valid = 0;
    tick();
    check_all("post_flush");

    // 17 retirements on the 4-bit counter wrap to 1.
    rst_n = 0; tick(); rst_n = 1;
    drive(3'd3, 3'd0, 3'd0, 0, 0, 0, 32'h77, 5'd1);
    for (int i = 0; i < 17; i++) tick();
    in_valid = 0;
    tick();
    chk("wrap.instret_w4", instret_w, 4'd1);
    chk("wrap.instret", instret, 17);
    check_all("wrap");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst_n       = ($urandom_range(0, 99) >= 2);
      in_valid    = ($urandom_range(0, 99) < 70);
      stall       = ($urandom_range(0, 99) < 25);
      flush       = ($urandom_range(0, 99) < 10);
      pc          = $urandom;
      imm         = $urandom;
      alu_out     = $urandom;
      mem_rdata   = $urandom;
      mem_addr_lo = 3'($urandom_range(0, 7));
      funct3      = 3'(f3_pick[$urandom_range(0, 4)]);
      wb_sel      = 3'($urandom_range(0, 7));
      rd_addr     = 5'($urandom_range(0, 31));
      rd_we       = ($urandom_range(0, 99) < 80);
      tick();
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
